// File: rtl/stream_deserializer_pkg.sv
// Shared types and helpers for the beat-to-word stream deserializer.
package stream_deserializer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Lane written by beat number idx of a group; big-endian mirrors the lane order.
    function automatic int unsigned lane_of(input int unsigned idx, input logic order,
                                            input int unsigned ratio);
        return order ? (ratio - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/stream_deserializer_slot.sv
// One-entry output register: loads a finished word, drains on out_ready.
module stream_deserializer_slot #(
    parameter int DATA_WIDTH  = 8,
    parameter int RATIO       = 4,
    parameter int COUNT_WIDTH = $clog2(RATIO + 1)
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             load,
    input  logic [RATIO-1:0][DATA_WIDTH-1:0] load_data,
    input  logic [COUNT_WIDTH-1:0]           load_count,
    input  logic                             load_last,
    input  logic                             out_ready,
    output logic                             slot_free,
    output logic                             out_valid,
    output logic [RATIO-1:0][DATA_WIDTH-1:0] out_data,
    output logic [COUNT_WIDTH-1:0]           out_count,
    output logic                             out_last
);

    assign slot_free = !out_valid || out_ready;

    // load is only raised while the slot is free, so a load always wins over a drain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_count <= load_count;
            out_last  <= load_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_deserializer.sv
// Packs DATA_WIDTH-bit beats into RATIO-lane words with per-group endianness and early termination.
module stream_deserializer
    import stream_deserializer_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int RATIO       = 4,
    parameter int COUNT_WIDTH = $clog2(RATIO + 1)
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_last,
    input  logic                             big_endian,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [RATIO-1:0][DATA_WIDTH-1:0] out_data,
    output logic [COUNT_WIDTH-1:0]           out_count,
    output logic                             out_last
);

    localparam int IDX_W = $clog2(RATIO);

    state_t                           state;
    logic [RATIO-1:0][DATA_WIDTH-1:0] lanes;
    logic [RATIO-1:0][DATA_WIDTH-1:0] merged;
    logic [IDX_W-1:0]                 idx;
    logic [IDX_W-1:0]                 tgt;
    logic                             order;
    logic                             cur_order;
    logic                             held_last;
    logic                             accept;
    logic                             complete;
    logic                             slot_free;
    logic                             load;
    logic [RATIO-1:0][DATA_WIDTH-1:0] load_data;
    logic [COUNT_WIDTH-1:0]           load_count;
    logic                             load_last;

    assign in_ready  = (state == FILL);
    assign accept    = in_valid && in_ready;
    assign cur_order = (idx == '0) ? big_endian : order;
    assign tgt       = IDX_W'(lane_of(32'(idx), cur_order, RATIO));
    assign complete  = accept && (in_last || idx == IDX_W'(RATIO - 1));

    // Lanes untouched by this group are still zero because the collector clears on every hand-off.
    always_comb begin
        merged      = lanes;
        merged[tgt] = in_data;
    end

    assign load       = slot_free && ((state == HOLD) || complete);
    assign load_data  = (state == HOLD) ? lanes : merged;
    assign load_count = COUNT_WIDTH'(idx) + COUNT_WIDTH'(1);
    assign load_last  = (state == HOLD) ? held_last : in_last;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= FILL;
            lanes     <= '0;
            idx       <= '0;
            order     <= 1'b0;
            held_last <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        order <= cur_order;
                        if (complete && slot_free) begin
                            lanes <= '0;
                            idx   <= '0;
                        end else if (complete) begin
                            lanes     <= merged;
                            held_last <= in_last;
                            state     <= HOLD;
                        end else begin
                            lanes <= merged;
                            idx   <= idx + IDX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        lanes <= '0;
                        idx   <= '0;
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    stream_deserializer_slot #(
        .DATA_WIDTH (DATA_WIDTH),
        .RATIO      (RATIO),
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_slot (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (load),
        .load_data (load_data),
        .load_count(load_count),
        .load_last (load_last),
        .out_ready (out_ready),
        .slot_free (slot_free),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_count (out_count),
        .out_last  (out_last)
    );

endmodule
